// File: rtl/spi_motor_regbank.sv
// spi_motor_regbank: decodes 32-bit SPI command words into PWM period registers,
// selects a readback word for the SPI return path, and supervises command
// traffic with a watchdog that forces every motor to a safe period on timeout.
module spi_motor_regbank #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_MOTORS  = 24,
  parameter int unsigned PWM_W       = 11,
  parameter int unsigned NUM_ENC     = 1,
  parameter int unsigned SETTLE      = 10,
  parameter int unsigned WDT_CYCLES  = 50_000_000,
  parameter int unsigned SAFE_PERIOD = 1,
  parameter int unsigned DEBUG_RESET = 1001
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [DATA_W-1:0]             cmd_word,
  input  logic                          data_ready,
  input  logic [NUM_ENC*16-1:0]         enc_count,
  input  logic [NUM_ENC-1:0]            enc_dir,
  output logic [NUM_MOTORS*PWM_W-1:0]   motor_periods,
  output logic [PWM_W-1:0]              debug_period,
  output logic [DATA_W-1:0]             readback,
  output logic                          fault,
  output logic                          cmd_strobe
);

  localparam int unsigned      WDT_W     = (WDT_CYCLES > 32'd1) ? $clog2(WDT_CYCLES) : 1;
  localparam logic [WDT_W-1:0] WDT_LAST  = (WDT_CYCLES > 32'd0) ? WDT_W'(WDT_CYCLES - 32'd1) : '0;
  localparam logic [PWM_W-1:0] SAFE_VAL  = PWM_W'(SAFE_PERIOD);
  localparam logic [PWM_W-1:0] DEBUG_VAL = PWM_W'(DEBUG_RESET);

  localparam logic [7:0] CMD_DRIVE  = 8'h00;
  localparam logic [7:0] CMD_SELECT = 8'h01;
  localparam logic [7:0] CMD_BCAST  = 8'h02;
  localparam logic [7:0] CMD_CLEAR  = 8'h03;
  localparam logic [7:0] RB_STATUS  = 8'h10;

  // Synchronizer (two flops) plus one history flop for the rising-edge detect.
  logic [2:0]                         sync_q, sync_d;
  logic [SETTLE-1:0]                  pipe_q, pipe_d;
  logic [NUM_MOTORS-1:0][PWM_W-1:0]   motor_q, motor_d;
  logic [PWM_W-1:0]                   debug_q, debug_d;
  logic [7:0]                         raddr_q, raddr_d;
  logic [7:0]                         bad_q, bad_d;
  logic                               fault_q, fault_d;
  logic                               strobe_q, strobe_d;
  logic [WDT_W-1:0]                   wdt_q, wdt_d;

  logic                               rise_s;
  logic                               apply_s;
  logic [7:0]                         cmd_s, maddr_s, raddr_s;
  logic [PWM_W-1:0]                   period_s;
  logic                               drive_ok_s, sel_s, bcast_s, clr_s;
  logic                               valid_s, bad_s, timeout_s;
  logic                               drive_wr_s, bcast_wr_s;
  logic [DATA_W-1:0]                  enc_word_s, mot_word_s, rb_s;
  logic                               enc_hit_s, mot_hit_s;

  // Field extraction and classification of the command leaving the settle pipe.
  always_comb begin
    rise_s     = sync_q[1] & ~sync_q[2];
    apply_s    = pipe_q[SETTLE-1];
    cmd_s      = cmd_word[DATA_W-1 -: 8];
    maddr_s    = cmd_word[18:11];
    raddr_s    = cmd_word[7:0];
    period_s   = cmd_word[PWM_W-1:0];
    drive_ok_s = apply_s && (cmd_s == CMD_DRIVE) && (32'(maddr_s) < NUM_MOTORS);
    sel_s      = apply_s && (cmd_s == CMD_SELECT);
    bcast_s    = apply_s && (cmd_s == CMD_BCAST);
    clr_s      = apply_s && (cmd_s == CMD_CLEAR);
    valid_s    = drive_ok_s || sel_s || bcast_s || clr_s;
    bad_s      = apply_s && !valid_s;
    // A command landing on the timeout edge wins over the watchdog.
    timeout_s  = (WDT_CYCLES != 32'd0) && (wdt_q == WDT_LAST) && !fault_q && !valid_s;
    // Motor writes are suppressed while in the safe state.
    drive_wr_s = drive_ok_s && !fault_q;
    bcast_wr_s = bcast_s && !fault_q;
  end

  // Next state of the synchronizer chain and the settle shift register.
  always_comb begin
    sync_d    = {sync_q[1:0], data_ready};
    pipe_d    = '0;
    pipe_d[0] = rise_s;
    for (int unsigned i = 1; i < SETTLE; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Next state of the motor period registers: timeout > broadcast > drive.
  always_comb begin
    motor_d = motor_q;
    if (timeout_s) begin
      for (int unsigned m = 0; m < NUM_MOTORS; m++) begin
        motor_d[m] = SAFE_VAL;
      end
    end else if (bcast_wr_s) begin
      for (int unsigned m = 0; m < NUM_MOTORS; m++) begin
        motor_d[m] = period_s;
      end
    end else if (drive_wr_s) begin
      for (int unsigned m = 0; m < NUM_MOTORS; m++) begin
        motor_d[m] = (32'(maddr_s) == m) ? period_s : motor_q[m];
      end
    end else begin
      motor_d = motor_q;
    end
  end

  // Next state of debug period, readback select, bad counter, fault, watchdog and strobe.
  always_comb begin
    debug_d  = drive_wr_s ? period_s : debug_q;
    raddr_d  = sel_s ? raddr_s : raddr_q;
    strobe_d = valid_s;
    if (bad_s && (bad_q != 8'hFF)) begin
      bad_d = bad_q + 8'd1;
    end else begin
      bad_d = bad_q;
    end
    if (clr_s) begin
      fault_d = 1'b0;
    end else if (timeout_s) begin
      fault_d = 1'b1;
    end else begin
      fault_d = fault_q;
    end
    if (WDT_CYCLES == 32'd0) begin
      wdt_d = '0;
    end else if (valid_s) begin
      wdt_d = '0;
    end else if (wdt_q != WDT_LAST) begin
      wdt_d = wdt_q + WDT_W'(1);
    end else begin
      wdt_d = wdt_q;
    end
  end

  // State registers; reset leaves every motor in the safe period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= '0;
      pipe_q   <= '0;
      motor_q  <= {NUM_MOTORS{SAFE_VAL}};
      debug_q  <= DEBUG_VAL;
      raddr_q  <= 8'h00;
      bad_q    <= 8'h00;
      fault_q  <= 1'b0;
      strobe_q <= 1'b0;
      wdt_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      pipe_q   <= pipe_d;
      motor_q  <= motor_d;
      debug_q  <= debug_d;
      raddr_q  <= raddr_d;
      bad_q    <= bad_d;
      fault_q  <= fault_d;
      strobe_q <= strobe_d;
      wdt_q    <= wdt_d;
    end
  end

  // Candidate readback words for the encoder and motor address windows.
  always_comb begin
    enc_hit_s  = (raddr_q != 8'h00) && (32'(raddr_q) <= NUM_ENC);
    mot_hit_s  = (32'(raddr_q) >= 32'd32) && (32'(raddr_q) < (32'd32 + NUM_MOTORS));
    enc_word_s = '0;
    mot_word_s = '0;
    for (int unsigned e = 0; e < NUM_ENC; e++) begin
      enc_word_s = (32'(raddr_q) == (e + 32'd1))
                   ? DATA_W'({15'd0, enc_dir[e], enc_count[16*e +: 16]}) : enc_word_s;
    end
    for (int unsigned m = 0; m < NUM_MOTORS; m++) begin
      mot_word_s = (32'(raddr_q) == (32'd32 + m)) ? DATA_W'(motor_q[m]) : mot_word_s;
    end
  end

  // Readback mux; unmapped addresses echo the current SPI word.
  always_comb begin
    if (raddr_q == 8'h00) begin
      rb_s = DATA_W'(debug_q);
    end else if (raddr_q == RB_STATUS) begin
      rb_s = DATA_W'({fault_q, 15'd0, 8'd0, bad_q});
    end else if (enc_hit_s) begin
      rb_s = enc_word_s;
    end else if (mot_hit_s) begin
      rb_s = mot_word_s;
    end else begin
      rb_s = cmd_word;
    end
  end

  assign motor_periods = motor_q;
  assign debug_period  = debug_q;
  assign fault         = fault_q;
  assign cmd_strobe    = strobe_q;
  assign readback      = rb_s;

endmodule

// File: tb/tb_spi_motor_regbank.sv
// Self-checking bench for spi_motor_regbank: a reference model predicts the
// register state of every applied command, a scoreboard holds those
// predictions, and a monitor pops them on each cmd_strobe.
module tb_spi_motor_regbank;

  localparam int DATA_W      = 32;
  localparam int NUM_MOTORS  = 24;
  localparam int PWM_W       = 11;
  localparam int NUM_ENC     = 1;
  localparam int SETTLE      = 10;
  localparam int WDT_CYCLES  = 100;
  localparam int SAFE_PERIOD = 1;
  localparam int DEBUG_RESET = 1001;

  logic                        clk = 1'b0;
  logic                        reset_n;
  logic [DATA_W-1:0]           cmd_word;
  logic                        data_ready;
  logic [NUM_ENC*16-1:0]       enc_count;
  logic [NUM_ENC-1:0]          enc_dir;
  logic [NUM_MOTORS*PWM_W-1:0] motor_periods;
  logic [PWM_W-1:0]            debug_period;
  logic [DATA_W-1:0]           readback;
  logic                        fault;
  logic                        cmd_strobe;

  int n_checks = 0;
  int n_fail   = 0;

  spi_motor_regbank #(
    .DATA_W(DATA_W), .NUM_MOTORS(NUM_MOTORS), .PWM_W(PWM_W), .NUM_ENC(NUM_ENC),
    .SETTLE(SETTLE), .WDT_CYCLES(WDT_CYCLES), .SAFE_PERIOD(SAFE_PERIOD),
    .DEBUG_RESET(DEBUG_RESET)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cmd_word(cmd_word), .data_ready(data_ready),
    .enc_count(enc_count), .enc_dir(enc_dir), .motor_periods(motor_periods),
    .debug_period(debug_period), .readback(readback), .fault(fault),
    .cmd_strobe(cmd_strobe)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [PWM_W-1:0] m_motor [NUM_MOTORS];
  logic [PWM_W-1:0] m_debug;
  logic             m_fault;
  logic [7:0]       m_bad;
  logic [7:0]       m_raddr;

  typedef struct packed {
    logic [NUM_MOTORS*PWM_W-1:0] motors;
    logic [PWM_W-1:0]            debug;
    logic                        flt;
    logic [31:0]                 rb;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  function automatic void model_reset();
    for (int m = 0; m < NUM_MOTORS; m++) m_motor[m] = PWM_W'(SAFE_PERIOD);
    m_debug = PWM_W'(DEBUG_RESET);
    m_fault = 1'b0;
    m_bad   = 8'd0;
    m_raddr = 8'd0;
  endfunction

  function automatic void model_timeout();
    m_fault = 1'b1;
    for (int m = 0; m < NUM_MOTORS; m++) m_motor[m] = PWM_W'(SAFE_PERIOD);
  endfunction

  function automatic logic [NUM_MOTORS*PWM_W-1:0] model_motors();
    logic [NUM_MOTORS*PWM_W-1:0] p;
    p = '0;
    for (int m = 0; m < NUM_MOTORS; m++) p[m*PWM_W +: PWM_W] = m_motor[m];
    return p;
  endfunction

  function automatic logic [31:0] model_rb(input logic [31:0] word);
    int a;
    a = int'(m_raddr);
    if (a == 0)                         return {21'd0, m_debug};
    else if (a >= 1 && a <= NUM_ENC)    return {15'd0, enc_dir[a-1], enc_count[(a-1)*16 +: 16]};
    else if (a == 16)                   return {m_fault, 15'd0, 8'd0, m_bad};
    else if (a >= 32 && a < 32 + NUM_MOTORS) return {21'd0, m_motor[a-32]};
    else                                return word;
  endfunction

  // Updates the model for one applied command; returns 1 when it is valid.
  function automatic logic model_apply(input logic [31:0] word);
    logic [7:0]       c;
    int               ma;
    logic [PWM_W-1:0] per;
    logic             ok;
    c   = word[31:24];
    ma  = int'(word[18:11]);
    per = word[PWM_W-1:0];
    ok  = 1'b1;
    case (c)
      8'h00: begin
        if (ma < NUM_MOTORS) begin
          if (!m_fault) begin m_motor[ma] = per; m_debug = per; end
        end else ok = 1'b0;
      end
      8'h01: m_raddr = word[7:0];
      8'h02: if (!m_fault) for (int m = 0; m < NUM_MOTORS; m++) m_motor[m] = per;
      8'h03: m_fault = 1'b0;
      default: ok = 1'b0;
    endcase
    if (!ok && m_bad != 8'hFF) m_bad = m_bad + 8'd1;
    return ok;
  endfunction

  function automatic exp_t snapshot(input logic [31:0] word);
    exp_t e;
    e.motors = model_motors();
    e.debug  = m_debug;
    e.flt    = m_fault;
    e.rb     = model_rb(word);
    return e;
  endfunction

  // Monitor: every strobe must match the oldest outstanding prediction.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && cmd_strobe === 1'b1) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_strobe: got strobe with empty scoreboard, expected none");
      end else begin
        mon_e = sb_q.pop_front();
        if (motor_periods !== mon_e.motors) begin
          n_fail++;
          $display("FAIL sb_motors: got %h expected %h", motor_periods, mon_e.motors);
        end
        n_checks++;
        if (debug_period !== mon_e.debug) begin
          n_fail++;
          $display("FAIL sb_debug: got %0d expected %0d", debug_period, mon_e.debug);
        end
        n_checks++;
        if (fault !== mon_e.flt) begin
          n_fail++;
          $display("FAIL sb_fault: got %b expected %b", fault, mon_e.flt);
        end
        n_checks++;
        if (readback !== mon_e.rb) begin
          n_fail++;
          $display("FAIL sb_readback: got %h expected %h", readback, mon_e.rb);
        end
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    data_ready = 1'b0;
    cmd_word   = 32'd0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    model_reset();
    sb_q.delete();
  endtask

  // One command: rising edge of data_ready, then check apply latency and strobe width.
  task automatic send_cmd(input logic [31:0] word);
    logic exp_strobe;
    cmd_word   = word;
    data_ready = 1'b1;
    exp_strobe = model_apply(word);
    if (exp_strobe) sb_q.push_back(snapshot(word));
    for (int e = 0; e <= 13; e++) begin
      tick();
      if (e == 2) data_ready = 1'b0;
      if (e == 11) begin
        n_checks++;
        if (cmd_strobe !== 1'b0) begin
          n_fail++;
          $display("FAIL strobe_early: got %b expected 0 (word %h)", cmd_strobe, word);
        end
      end
      if (e == 12) begin
        n_checks++;
        if (cmd_strobe !== exp_strobe) begin
          n_fail++;
          $display("FAIL strobe_apply: got %b expected %b (word %h)", cmd_strobe, exp_strobe, word);
        end
      end
      if (e == 13) begin
        n_checks++;
        if (cmd_strobe !== 1'b0) begin
          n_fail++;
          $display("FAIL strobe_width: got %b expected 0 (word %h)", cmd_strobe, word);
        end
        n_checks++;
        if (sb_q.size() != 0) begin
          n_fail++;
          $display("FAIL sb_drain: got %0d pending expected 0 (word %h)", sb_q.size(), word);
          sb_q.delete();
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (motor_periods !== {NUM_MOTORS{11'd1}}) begin
      n_fail++; $display("FAIL reset_motors: got %h expected all 1", motor_periods);
    end
    n_checks++;
    if (readback !== 32'd1001) begin
      n_fail++; $display("FAIL reset_readback: got %0d expected 1001", readback);
    end
    n_checks++;
    if (fault !== 1'b0 || cmd_strobe !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got fault %b strobe %b expected 0 0", fault, cmd_strobe);
    end
    n_checks++;
    if (debug_period !== 11'd1001) begin
      n_fail++; $display("FAIL reset_debug: got %0d expected 1001", debug_period);
    end
  endtask

  task automatic test_drive();
    do_reset();
    send_cmd(32'h0000_1BE8);
    n_checks++;
    if (motor_periods[3*PWM_W +: PWM_W] !== 11'd1000 || debug_period !== 11'd1000) begin
      n_fail++;
      $display("FAIL drive_m3: got m3 %0d debug %0d expected 1000 1000",
               motor_periods[3*PWM_W +: PWM_W], debug_period);
    end
    send_cmd(32'h0000_B805);   // last motor, period 5
    send_cmd(32'h0000_C007);   // maddr 24: out of range
  endtask

  task automatic test_bad_cmd();
    do_reset();
    send_cmd(32'h0000_F00A);   // maddr 30: out of range
    send_cmd(32'h0700_0000);   // unknown command
    send_cmd(32'h0100_0010);   // select status
    n_checks++;
    if (readback !== 32'h0000_0002) begin
      n_fail++; $display("FAIL bad_count2: got %h expected 00000002", readback);
    end
    cmd_word = 32'hFF00_0000;
    for (int i = 0; i < 300; i++) begin
      data_ready = 1'b1;
      void'(model_apply(cmd_word));
      tick(); tick();
      data_ready = 1'b0;
      tick(); tick();
    end
    repeat (15) tick();
    model_timeout();           // far more than WDT_CYCLES without a valid command
    send_cmd(32'h0100_0010);
    n_checks++;
    if (readback !== 32'h8000_00FF) begin
      n_fail++; $display("FAIL bad_saturate: got %h expected 800000ff", readback);
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    send_cmd(32'h0200_01F4);   // broadcast 500
    repeat (98) tick();
    n_checks++;
    if (fault !== 1'b0) begin
      n_fail++; $display("FAIL wdt_early: got fault %b expected 0", fault);
    end
    tick();
    model_timeout();
    n_checks++;
    if (fault !== 1'b1 || motor_periods !== model_motors()) begin
      n_fail++; $display("FAIL wdt_fire: got fault %b motors %h expected 1 %h",
                         fault, motor_periods, model_motors());
    end
    send_cmd(32'h0200_02BC);   // broadcast 700 ignored while faulted
    send_cmd(32'h0300_0000);   // clear fault
    send_cmd(32'h0200_02BC);   // broadcast 700 now applies
    n_checks++;
    if (motor_periods !== {NUM_MOTORS{11'd700}} || fault !== 1'b0) begin
      n_fail++; $display("FAIL wdt_recover: got fault %b motors %h expected 0 all 700",
                         fault, motor_periods);
    end
  endtask

  task automatic test_readback();
    do_reset();
    enc_count = 16'h1234;
    enc_dir   = 1'b1;
    send_cmd(32'h0000_1BE8);
    send_cmd(32'h0100_0001);
    n_checks++;
    if (readback !== 32'h0001_1234) begin
      n_fail++; $display("FAIL rb_enc: got %h expected 00011234", readback);
    end
    enc_count = 16'h00F0;
    enc_dir   = 1'b0;
    tick();
    n_checks++;
    if (readback !== 32'h0000_00F0) begin
      n_fail++; $display("FAIL rb_enc_live: got %h expected 000000f0", readback);
    end
    send_cmd(32'h0100_0023);
    n_checks++;
    if (readback !== 32'd1000) begin
      n_fail++; $display("FAIL rb_motor3: got %h expected 1000", readback);
    end
    send_cmd(32'h0100_0050);
    cmd_word = 32'hDEAD_BEEF;
    tick();
    n_checks++;
    if (readback !== model_rb(cmd_word)) begin
      n_fail++; $display("FAIL rb_echo: got %h expected %h", readback, model_rb(cmd_word));
    end
  endtask

  task automatic test_reset_mid_cmd();
    logic seen;
    do_reset();
    seen       = 1'b0;
    cmd_word   = 32'h0000_1BE8;
    data_ready = 1'b1;
    for (int e = 0; e <= 5; e++) begin
      tick();
      if (e == 2) data_ready = 1'b0;
    end
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    for (int e = 0; e < 20; e++) begin
      tick();
      if (cmd_strobe !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_strobe: got strobe pulse expected none");
    end
    n_checks++;
    if (motor_periods !== {NUM_MOTORS{11'd1}} || debug_period !== 11'd1001) begin
      n_fail++; $display("FAIL rst_mid_regs: got motors %h debug %0d expected all 1, 1001",
                         motor_periods, debug_period);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cmd_word   = 32'h0000_284D;  // motor 5, period 77
    data_ready = 1'b1;
    void'(model_apply(cmd_word));
    sb_q.push_back(snapshot(cmd_word));
    for (int e = 0; e <= 17; e++) begin
      tick();
      if (e == 1) data_ready = 1'b0;
      if (e == 3) data_ready = 1'b1;
      if (e == 5) data_ready = 1'b0;
      if (e == 12) begin
        n_checks++;
        if (cmd_strobe !== 1'b1) begin
          n_fail++; $display("FAIL b2b_first: got strobe %b expected 1", cmd_strobe);
        end
      end
      if (e == 13) begin
        cmd_word = 32'h0000_3058;  // motor 6, period 88
        void'(model_apply(cmd_word));
        sb_q.push_back(snapshot(cmd_word));
      end
      if (e == 16) begin
        n_checks++;
        if (cmd_strobe !== 1'b1) begin
          n_fail++; $display("FAIL b2b_second: got strobe %b expected 1", cmd_strobe);
        end
      end
    end
    n_checks++;
    if (sb_q.size() != 0 || motor_periods[5*PWM_W +: PWM_W] !== 11'd77 ||
        motor_periods[6*PWM_W +: PWM_W] !== 11'd88) begin
      n_fail++;
      $display("FAIL b2b_regs: got pending %0d m5 %0d m6 %0d expected 0 77 88", sb_q.size(),
               motor_periods[5*PWM_W +: PWM_W], motor_periods[6*PWM_W +: PWM_W]);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    data_ready = 1'b0;
    cmd_word   = 32'd0;
    enc_count  = 16'hABCD;
    enc_dir    = 1'b0;
    test_reset();
    test_drive();
    test_bad_cmd();
    test_watchdog();
    test_readback();
    test_reset_mid_cmd();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
